// File: rtl/sdram_multi_port_facade.sv
// sdram_multi_port_facade
// Arbitrates Channels pixel-write sources and one pixel-read sink onto a
// single burst-oriented SDRAM controller port. Each write channel owns a
// frame-sized SDRAM region with its own wrapping offset; the read stream
// follows a channel latched at frame boundaries.
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   i_wr_req/i_wr_pixel   per-channel burst-ready flags and packed pixel slices
//   o_wr_ack/o_busy_wr    per-channel beat acknowledge / grant indicator
//   i_rd_req/i_rd_channel reader burst request and source channel
//   o_rd_pixel/o_rd_valid registered read data, o_rd_frame_start on pixel 0
//   o_busy_rd             read grant indicator
//   i_sdram_*             controller busy, write/read beat strobes, read data
//   o_sdram_*             command request, direction, write data, burst address
module sdram_multi_port_facade #(
   parameter int Channels          = 2,
   parameter int FrameWidth        = 640,
   parameter int FrameHeight       = 480,
   parameter int BurstLengthSDRAM  = 8,
   parameter int PixelBitWidth     = 16,
   parameter int AddressWidthSDRAM = 24,
   parameter int ReadPriority      = 1,
   localparam int ChW = (Channels > 1) ? $clog2(Channels) : 1
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [Channels-1:0]                 i_wr_req,
   input  logic [Channels*PixelBitWidth-1:0]   i_wr_pixel,
   output logic [Channels-1:0]                 o_wr_ack,
   output logic [Channels-1:0]                 o_busy_wr,
   input  logic                                i_rd_req,
   input  logic [ChW-1:0]                      i_rd_channel,
   output logic [PixelBitWidth-1:0]            o_rd_pixel,
   output logic                                o_rd_valid,
   output logic                                o_rd_frame_start,
   output logic                                o_busy_rd,
   input  logic                                i_sdram_busy,
   input  logic                                i_sdram_valid_wr,
   input  logic                                i_sdram_valid_rd,
   input  logic [PixelBitWidth-1:0]            i_sdram_pixel,
   output logic                                o_sdram_enable,
   output logic                                o_sdram_read,
   output logic [PixelBitWidth-1:0]            o_sdram_pixel,
   output logic [AddressWidthSDRAM-1:0]        o_sdram_addr
);

   localparam int AW         = AddressWidthSDRAM;
   localparam int FrameWords = FrameWidth * FrameHeight;
   // Ring of write slots; with read-last arbitration the read is slot Channels.
   localparam int RingN      = (ReadPriority != 0) ? Channels : Channels + 1;
   localparam int RingW      = $clog2(Channels + 1);
   localparam int BeatW      = $clog2(BurstLengthSDRAM + 1);
   localparam logic [AW-1:0] FrameWordsA = AW'(FrameWords);
   localparam logic [AW-1:0] BurstA      = AW'(BurstLengthSDRAM);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;

   state_t            state_r;
   logic [RingW-1:0]  rr_r;
   logic              grant_rd_r;
   logic [ChW-1:0]    grant_ch_r;
   logic [ChW-1:0]    rd_ch_r;
   logic [AW-1:0]     rd_off_r;
   logic [AW-1:0]     wr_off_r [Channels];
   logic [BeatW-1:0]  beat_cnt_r;

   logic [Channels:0] req_ring_s;
   logic              arb_any_s;
   logic [RingW-1:0]  arb_pick_s;
   logic [RingW-1:0]  rr_next_s;
   logic              pick_rd_s;
   logic [ChW-1:0]    pick_ch_s;
   logic [ChW-1:0]    rd_src_ch_s;
   logic [AW-1:0]     grant_addr_s;
   logic [AW-1:0]     cur_off_s;
   logic [AW-1:0]     sum_off_s;
   logic [AW-1:0]     next_off_s;
   logic              wr_beat_s;
   logic              rd_beat_s;
   logic              last_beat_s;

   assign req_ring_s = {i_rd_req, i_wr_req};

   // Pick the next requester: optional read override, then the round-robin ring.
   always_comb begin
      int idx;
      idx        = 32'sd0;
      arb_any_s  = 1'b0;
      arb_pick_s = {RingW{1'b0}};
      if ((ReadPriority != 0) && i_rd_req) begin
         arb_any_s  = 1'b1;
         arb_pick_s = RingW'(Channels);
      end else begin
         for (int k = 0; k < RingN; k++) begin
            idx = int'(rr_r) + k;
            if (idx >= RingN) begin
               idx = idx - RingN;
            end else begin
               idx = idx;
            end
            if (!arb_any_s && req_ring_s[RingW'(idx)]) begin
               arb_any_s  = 1'b1;
               arb_pick_s = RingW'(idx);
            end else begin
               arb_any_s  = arb_any_s;
            end
         end
      end
   end

   assign rr_next_s   = (arb_pick_s == RingW'(RingN - 1)) ? {RingW{1'b0}} : arb_pick_s + 1'b1;
   assign pick_rd_s   = (arb_pick_s == RingW'(Channels));
   assign pick_ch_s   = ChW'(arb_pick_s);
   // The read source channel only changes when a new frame starts.
   assign rd_src_ch_s = (rd_off_r == {AW{1'b0}}) ? i_rd_channel : rd_ch_r;
   assign grant_addr_s = pick_rd_s ? (AW'(rd_src_ch_s) * FrameWordsA + rd_off_r)
                                   : (AW'(pick_ch_s) * FrameWordsA + wr_off_r[pick_ch_s]);

   assign cur_off_s  = grant_rd_r ? rd_off_r : wr_off_r[grant_ch_r];
   assign sum_off_s  = cur_off_s + BurstA;
   assign next_off_s = (sum_off_s == FrameWordsA) ? {AW{1'b0}} : sum_off_s;

   // Only strobes matching the granted direction during XFER count as beats.
   assign wr_beat_s   = (state_r == XFER) && !grant_rd_r && i_sdram_valid_wr;
   assign rd_beat_s   = (state_r == XFER) &&  grant_rd_r && i_sdram_valid_rd;
   assign last_beat_s = (wr_beat_s || rd_beat_s) &&
                        (beat_cnt_r == BeatW'(BurstLengthSDRAM - 1));

   assign o_wr_ack      = wr_beat_s ? (Channels'(1'b1) << grant_ch_r) : {Channels{1'b0}};
   assign o_sdram_pixel = wr_beat_s ? i_wr_pixel[grant_ch_r * PixelBitWidth +: PixelBitWidth]
                                    : {PixelBitWidth{1'b0}};

   // Burst FSM with registered command, address, busy flags and read data.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r          <= IDLE;
         rr_r             <= {RingW{1'b0}};
         grant_rd_r       <= 1'b0;
         grant_ch_r       <= {ChW{1'b0}};
         rd_ch_r          <= {ChW{1'b0}};
         rd_off_r         <= {AW{1'b0}};
         for (int c = 0; c < Channels; c++) begin
            wr_off_r[c]   <= {AW{1'b0}};
         end
         beat_cnt_r       <= {BeatW{1'b0}};
         o_sdram_enable   <= 1'b0;
         o_sdram_read     <= 1'b0;
         o_sdram_addr     <= {AW{1'b0}};
         o_busy_wr        <= {Channels{1'b0}};
         o_busy_rd        <= 1'b0;
         o_rd_pixel       <= {PixelBitWidth{1'b0}};
         o_rd_valid       <= 1'b0;
         o_rd_frame_start <= 1'b0;
      end else begin
         o_rd_valid       <= rd_beat_s;
         o_rd_frame_start <= rd_beat_s && (rd_off_r == {AW{1'b0}}) &&
                             (beat_cnt_r == {BeatW{1'b0}});
         if (rd_beat_s) begin
            o_rd_pixel <= i_sdram_pixel;
         end
         case (state_r)
            IDLE: begin
               if (!i_sdram_busy && arb_any_s) begin
                  state_r        <= CMD;
                  grant_rd_r     <= pick_rd_s;
                  grant_ch_r     <= pick_ch_s;
                  beat_cnt_r     <= {BeatW{1'b0}};
                  o_sdram_enable <= 1'b1;
                  o_sdram_read   <= pick_rd_s;
                  o_sdram_addr   <= grant_addr_s;
                  o_busy_rd      <= pick_rd_s;
                  o_busy_wr      <= pick_rd_s ? {Channels{1'b0}} : (Channels'(1'b1) << pick_ch_s);
                  // A priority read sits outside the write ring and leaves it alone.
                  if (!(pick_rd_s && (ReadPriority != 0))) begin
                     rr_r <= rr_next_s;
                  end
                  if (pick_rd_s) begin
                     rd_ch_r <= rd_src_ch_s;
                  end
               end
            end
            CMD: begin
               if (i_sdram_busy) begin
                  state_r        <= XFER;
                  o_sdram_enable <= 1'b0;
                  o_sdram_read   <= 1'b0;
               end
            end
            XFER: begin
               if (last_beat_s) begin
                  state_r    <= DONE;
                  beat_cnt_r <= {BeatW{1'b0}};
                  if (grant_rd_r) begin
                     rd_off_r <= next_off_s;
                  end else begin
                     wr_off_r[grant_ch_r] <= next_off_s;
                  end
               end else if (wr_beat_s || rd_beat_s) begin
                  beat_cnt_r <= beat_cnt_r + 1'b1;
               end
            end
            DONE: begin
               if (!i_sdram_busy) begin
                  state_r      <= IDLE;
                  o_sdram_addr <= {AW{1'b0}};
                  o_busy_wr    <= {Channels{1'b0}};
                  o_busy_rd    <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_multi_port_facade.sv
// Directed bench: instance 0 uses the default 640x480 frame with read
// priority, instance 1 uses a 4x4 frame with the read as a round-robin slot.
module tb_sdram_multi_port_facade;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]             rst_n;
   logic [1:0][1:0]        wr_req;
   logic [1:0][31:0]       wr_px;
   logic [1:0]             rd_req;
   logic [1:0][0:0]        rd_ch;
   logic [1:0]             busy, vwr, vrd;
   logic [1:0][15:0]       sd_in;
   logic [1:0][1:0]        ack, busy_wr;
   logic [1:0][15:0]       rd_px, sd_out;
   logic [1:0]             rd_v, fs, busy_rd, en, rdcmd;
   logic [1:0][23:0]       addr;

   int checks = 0;
   int errors = 0;

   sdram_multi_port_facade #(.Channels(2), .ReadPriority(1)) dut_a (
      .CLK(clk), .RST(rst_n[0]), .i_wr_req(wr_req[0]), .i_wr_pixel(wr_px[0]),
      .o_wr_ack(ack[0]), .o_busy_wr(busy_wr[0]), .i_rd_req(rd_req[0]),
      .i_rd_channel(rd_ch[0]), .o_rd_pixel(rd_px[0]), .o_rd_valid(rd_v[0]),
      .o_rd_frame_start(fs[0]), .o_busy_rd(busy_rd[0]), .i_sdram_busy(busy[0]),
      .i_sdram_valid_wr(vwr[0]), .i_sdram_valid_rd(vrd[0]), .i_sdram_pixel(sd_in[0]),
      .o_sdram_enable(en[0]), .o_sdram_read(rdcmd[0]), .o_sdram_pixel(sd_out[0]),
      .o_sdram_addr(addr[0]));

   sdram_multi_port_facade #(.Channels(2), .FrameWidth(4), .FrameHeight(4),
                             .ReadPriority(0)) dut_b (
      .CLK(clk), .RST(rst_n[1]), .i_wr_req(wr_req[1]), .i_wr_pixel(wr_px[1]),
      .o_wr_ack(ack[1]), .o_busy_wr(busy_wr[1]), .i_rd_req(rd_req[1]),
      .i_rd_channel(rd_ch[1]), .o_rd_pixel(rd_px[1]), .o_rd_valid(rd_v[1]),
      .o_rd_frame_start(fs[1]), .o_busy_rd(busy_rd[1]), .i_sdram_busy(busy[1]),
      .i_sdram_valid_wr(vwr[1]), .i_sdram_valid_rd(vrd[1]), .i_sdram_pixel(sd_in[1]),
      .o_sdram_enable(en[1]), .o_sdram_read(rdcmd[1]), .o_sdram_pixel(sd_out[1]),
      .o_sdram_addr(addr[1]));

   // One full burst acting as the SDRAM controller; requests are replaced by
   // wr_after/rd_after once the command is seen.
   task automatic run_burst(input int d, input string tag, input bit exp_rd,
                            input int exp_ch, input logic [23:0] exp_addr,
                            input logic [1:0] wr_after, input bit rd_after,
                            input bit fs_first, input bit inject);
      int t;
      bit got;
      logic [1:0] exp_bw;
      logic [15:0] ep, prev;
      got = 1'b0;
      t = 0;
      prev = 16'h0000;
      exp_bw = exp_rd ? 2'b00 : (2'b01 << exp_ch);
      while (t < 20 && !got) begin
         @(negedge clk);
         t++;
         got = en[d];
      end
      checks++;
      if (!got || t != 1) begin
         errors++;
         $display("FAIL %s enable latency: got=%0b cycles=%0d expected 1 cycle", tag, got, t);
         if (!got) begin
            wr_req[d] = 2'b00; rd_req[d] = 1'b0;
            return;
         end
      end
      checks++;
      if (addr[d] !== exp_addr) begin
         errors++; $display("FAIL %s addr: got %0d expected %0d", tag, addr[d], exp_addr);
      end
      checks++;
      if (rdcmd[d] !== exp_rd) begin
         errors++; $display("FAIL %s read cmd: got %b expected %b", tag, rdcmd[d], exp_rd);
      end
      checks++;
      if ({busy_rd[d], busy_wr[d]} !== {exp_rd, exp_bw}) begin
         errors++; $display("FAIL %s busy: got %b expected %b", tag, {busy_rd[d], busy_wr[d]}, {exp_rd, exp_bw});
      end
      wr_req[d] = wr_after;
      rd_req[d] = rd_after;
      busy[d] = 1'b1;
      @(negedge clk);
      checks++;
      if (en[d] !== 1'b0) begin
         errors++; $display("FAIL %s enable in xfer: got %b expected 0", tag, en[d]);
      end
      for (int b = 0; b <= 8; b++) begin
         if (inject && b == 3) begin
            vwr[d] = 1'b0; vrd[d] = 1'b1; sd_in[d] = 16'hDEAD;
            #1;
            checks++;
            if (ack[d] !== 2'b00) begin
               errors++; $display("FAIL %s wrong-strobe ack: got %b expected 00", tag, ack[d]);
            end
            @(negedge clk);
            vrd[d] = 1'b0;
            checks++;
            if (rd_v[d] !== 1'b0) begin
               errors++; $display("FAIL %s wrong-strobe rd_valid: got %b expected 0", tag, rd_v[d]);
            end
         end
         if (b < 8) begin
            if (exp_rd) begin
               vrd[d] = 1'b1; sd_in[d] = 16'hA000 + 16'(b) + (16'(exp_addr) << 4);
            end else begin
               vwr[d] = 1'b1; wr_px[d] = {16'h2200 + 16'(b), 16'h1100 + 16'(b)};
            end
         end else begin
            vwr[d] = 1'b0; vrd[d] = 1'b0; busy[d] = 1'b0;
         end
         #1;
         if (!exp_rd) begin
            checks++;
            if (ack[d] !== ((b < 8) ? exp_bw : 2'b00)) begin
               errors++; $display("FAIL %s ack beat %0d: got %b expected %b", tag, b, ack[d], (b < 8) ? exp_bw : 2'b00);
            end
            if (b < 8) begin
               ep = ((exp_ch == 0) ? 16'h1100 : 16'h2200) + 16'(b);
               checks++;
               if (sd_out[d] !== ep) begin
                  errors++; $display("FAIL %s wr pixel beat %0d: got %h expected %h", tag, b, sd_out[d], ep);
               end
            end
         end else if (b > 0) begin
            checks++;
            if ({rd_v[d], fs[d], rd_px[d]} !== {1'b1, fs_first && (b == 1), prev}) begin
               errors++; $display("FAIL %s rd beat %0d: valid/fs/pixel got %b/%b/%h expected 1/%b/%h",
                                  tag, b - 1, rd_v[d], fs[d], rd_px[d], fs_first && (b == 1), prev);
            end
         end
         prev = sd_in[d];
         if (b < 8) @(negedge clk);
      end
      checks++;
      if ({busy_rd[d], busy_wr[d]} !== {exp_rd, exp_bw}) begin
         errors++; $display("FAIL %s busy in done: got %b expected %b", tag, {busy_rd[d], busy_wr[d]}, {exp_rd, exp_bw});
      end
      @(negedge clk);
      checks++;
      if ({addr[d], busy_rd[d], busy_wr[d], en[d], rd_v[d]} !== 29'd0) begin
         errors++; $display("FAIL %s idle: addr=%0d busy=%b en=%b rd_valid=%b expected all 0",
                            tag, addr[d], {busy_rd[d], busy_wr[d]}, en[d], rd_v[d]);
      end
   endtask

   task automatic test_reset;
      rst_n = 2'b00; wr_req = '0; wr_px = '0; rd_req = '0; rd_ch = '0;
      busy = '0; vwr = '0; vrd = '0; sd_in = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({en[d], rdcmd[d], addr[d], sd_out[d], ack[d], rd_v[d], fs[d], rd_px[d], busy_wr[d], busy_rd[d]} !== '0) begin
            errors++; $display("FAIL reset dut%0d: en=%b rd=%b addr=%0d px=%h ack=%b v=%b fs=%b rpx=%h bw=%b br=%b expected all 0",
                               d, en[d], rdcmd[d], addr[d], sd_out[d], ack[d], rd_v[d], fs[d], rd_px[d], busy_wr[d], busy_rd[d]);
         end
      end
      rst_n = 2'b11;
      @(negedge clk);
   endtask

   task automatic test_single_channel;
      wr_req[0] = 2'b10;
      run_burst(0, "single_b0", 1'b0, 1, 24'd307200, 2'b10, 1'b0, 1'b0, 1'b0);
      run_burst(0, "single_b1", 1'b0, 1, 24'd307208, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_read_priority;
      rd_req[0] = 1'b1; wr_req[0] = 2'b01; rd_ch[0] = 1'b0;
      run_burst(0, "prio_rd", 1'b1, 0, 24'd0, 2'b01, 1'b0, 1'b1, 1'b0);
      run_burst(0, "prio_wr", 1'b0, 0, 24'd0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_wrong_strobe;
      wr_req[0] = 2'b01;
      run_burst(0, "wrong_strobe", 1'b0, 0, 24'd8, 2'b00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_burst;
      wr_req[0] = 2'b01;
      @(negedge clk);
      checks++;
      if ({en[0], addr[0]} !== {1'b1, 24'd16}) begin
         errors++; $display("FAIL midrst cmd: en=%b addr=%0d expected 1/16", en[0], addr[0]);
      end
      wr_req[0] = 2'b00; busy[0] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         vwr[0] = 1'b1; wr_px[0] = 32'h2200_1100;
         @(negedge clk);
      end
      rst_n[0] = 1'b0;
      #1;
      checks++;
      if ({en[0], rdcmd[0], addr[0], sd_out[0], ack[0], rd_v[0], fs[0], rd_px[0], busy_wr[0], busy_rd[0]} !== '0) begin
         errors++; $display("FAIL midrst outputs: en=%b addr=%0d px=%h ack=%b rpx=%h bw=%b expected all 0",
                            en[0], addr[0], sd_out[0], ack[0], rd_px[0], busy_wr[0]);
      end
      @(negedge clk);
      rst_n[0] = 1'b1; busy[0] = 1'b0;
      #1;
      checks++;
      if (ack[0] !== 2'b00) begin
         errors++; $display("FAIL midrst ack after release: got %b expected 00", ack[0]);
      end
      vwr[0] = 1'b0;
      wr_req[0] = 2'b01;
      run_burst(0, "after_rst", 1'b0, 0, 24'd0, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_round_robin;
      wr_req[1] = 2'b11;
      run_burst(1, "rr_g0", 1'b0, 0, 24'd0,  2'b11, 1'b0, 1'b0, 1'b0);
      run_burst(1, "rr_g1", 1'b0, 1, 24'd16, 2'b11, 1'b0, 1'b0, 1'b0);
      run_burst(1, "rr_g2", 1'b0, 0, 24'd8,  2'b11, 1'b0, 1'b0, 1'b0);
      run_burst(1, "rr_g3", 1'b0, 1, 24'd24, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_read_wrap;
      rd_req[1] = 1'b1; rd_ch[1] = 1'b0;
      run_burst(1, "rwrap_b0", 1'b1, 0, 24'd0,  2'b00, 1'b1, 1'b1, 1'b0);
      rd_ch[1] = 1'b1;
      run_burst(1, "rwrap_b1", 1'b1, 0, 24'd8,  2'b00, 1'b1, 1'b0, 1'b0);
      run_burst(1, "rwrap_b2", 1'b1, 0, 24'd16, 2'b00, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_read_priority();
      test_wrong_strobe();
      test_reset_mid_burst();
      test_round_robin();
      test_read_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
